// File: rtl/water_level_sensor_conditioner_if.sv
// rtl/water_level_sensor_conditioner_if.sv - float-switch inputs and conditioned level outputs
// Purpose: groups the raw switch inputs, fault clear and conditioned outputs of
//          water_level_sensor_conditioner.
// Signals: raw_s1/raw_s2/raw_s3 async float switches, fault_clr clear pulse,
//          S1/S2/S3 conditioned level bits, level_valid, sensor_fault, level_change,
//          change_count (only when WATER_LEVEL_CHANGE_COUNT_EN is defined).
// Modports: master = stimulus side, slave = conditioner side.
interface water_level_sensor_conditioner_if;
  logic        raw_s1;
  logic        raw_s2;
  logic        raw_s3;
  logic        fault_clr;
  logic        S1;
  logic        S2;
  logic        S3;
  logic        level_valid;
  logic        sensor_fault;
  logic        level_change;
`ifdef WATER_LEVEL_CHANGE_COUNT_EN
  logic [15:0] change_count;
`endif

  modport master (
    output raw_s1, raw_s2, raw_s3, fault_clr,
`ifdef WATER_LEVEL_CHANGE_COUNT_EN
    input  change_count,
`endif
    input  S1, S2, S3, level_valid, sensor_fault, level_change
  );

  modport slave (
    input  raw_s1, raw_s2, raw_s3, fault_clr,
`ifdef WATER_LEVEL_CHANGE_COUNT_EN
    output change_count,
`endif
    output S1, S2, S3, level_valid, sensor_fault, level_change
  );
endinterface

// File: rtl/water_level_sensor_conditioner.sv
// rtl/water_level_sensor_conditioner.sv - sync, debounce and plausibility check of float switches
// Purpose: conditions three bouncy async float switches into clean level bits S1..S3 for the
//          fill controller, and flags a sustained implausible pattern as sensor_fault.
// Ports:   clk   system clock (posedge)
//          reset synchronous active-low reset
//          lvl   slave modport: raw_s1..3, fault_clr in; S1..S3, level_valid, sensor_fault,
//                level_change out (+ change_count [15:0] when enabled)
// Config:  define WATER_LEVEL_CHANGE_COUNT_EN to add the saturating level_change counter.
module water_level_sensor_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int DB_W            = 16,
  parameter int FAULT_CYCLES    = 4000,
  parameter int FLT_W           = 16
) (
  input  logic                              clk,
  input  logic                              reset,
  water_level_sensor_conditioner_if.slave   lvl
);

  localparam logic [DB_W-1:0]  DB_LAST     = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DB_W-1:0]  STARTUP_LEN = DB_W'(DEBOUNCE_CYCLES + 2);
  localparam logic [FLT_W-1:0] FLT_TARGET  = FLT_W'(FAULT_CYCLES);
  localparam logic [FLT_W-1:0] FLT_MAX     = '1;

  logic [2:0]       raw;
  logic [2:0]       sync_a;
  logic [2:0]       sync_b;
  logic [2:0]       db;
  logic [DB_W-1:0]  db_cnt [3];
  logic [DB_W-1:0]  st_cnt;
  logic             startup_done;
  logic             plausible;
  logic [FLT_W-1:0] flt_cnt;
  logic [FLT_W-1:0] flt_inc;
  logic [2:0]       s_out;
  logic             valid_q;
  logic             fault_q;
  logic             change_q;

  assign raw = {lvl.raw_s3, lvl.raw_s2, lvl.raw_s1};

  // Two-flop synchroniser; resets to 1 so an idle reservoir reads as full.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sync_a <= 3'b111;
      sync_b <= 3'b111;
    end else begin
      sync_a <= raw;
      sync_b <= sync_a;
    end
  end

  // A bit flips only after DEBOUNCE_CYCLES consecutive disagreeing samples; any
  // agreeing sample restarts the run. The counter stops at DB_LAST so it never wraps.
  always_ff @(posedge clk) begin
    if (!reset) begin
      db <= 3'b111;
      for (int i = 0; i < 3; i++) db_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (sync_b[i] == db[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          db[i]     <= sync_b[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  // Startup window lets the debouncers settle before anything reaches the fill controller.
  assign startup_done = (st_cnt == STARTUP_LEN);

  always_ff @(posedge clk) begin
    if (!reset) begin
      st_cnt <= '0;
    end else if (!startup_done) begin
      st_cnt <= st_cnt + 1'b1;
    end
  end

  // Switches are stacked, so water can only cover them bottom-up.
  assign plausible = (db == 3'b000) || (db == 3'b001) || (db == 3'b011) || (db == 3'b111);
  assign flt_inc   = (flt_cnt == FLT_MAX) ? flt_cnt : flt_cnt + 1'b1;

  always_ff @(posedge clk) begin
    if (!reset) begin
      s_out    <= 3'b111;
      valid_q  <= 1'b0;
      fault_q  <= 1'b0;
      change_q <= 1'b0;
      flt_cnt  <= '0;
    end else if (!startup_done) begin
      s_out    <= 3'b111;
      valid_q  <= 1'b0;
      change_q <= 1'b0;
      flt_cnt  <= '0;
      if (lvl.fault_clr) fault_q <= 1'b0;
    end else begin
      if (plausible) begin
        s_out    <= db;
        valid_q  <= 1'b1;
        change_q <= (db != s_out);
      end else begin
        valid_q  <= 1'b0;
        change_q <= 1'b0;
      end
      // A fault being raised this cycle takes priority over a simultaneous clear.
      if (!plausible && (flt_inc == FLT_TARGET)) begin
        fault_q <= 1'b1;
      end else if (lvl.fault_clr) begin
        fault_q <= 1'b0;
      end
      if (lvl.fault_clr || plausible) begin
        flt_cnt <= '0;
      end else begin
        flt_cnt <= flt_inc;
      end
    end
  end

  assign lvl.S1           = s_out[0];
  assign lvl.S2           = s_out[1];
  assign lvl.S3           = s_out[2];
  assign lvl.level_valid  = valid_q;
  assign lvl.sensor_fault = fault_q;
  assign lvl.level_change = change_q;

`ifdef WATER_LEVEL_CHANGE_COUNT_EN
  logic [15:0] change_cnt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      change_cnt <= '0;
    end else if (change_q && (change_cnt != 16'hFFFF)) begin
      change_cnt <= change_cnt + 1'b1;
    end
  end

  assign lvl.change_count = change_cnt;
`endif

endmodule

// File: tb/tb_water_level_sensor_conditioner.sv
// tb/tb_water_level_sensor_conditioner.sv - self-checking bench for water_level_sensor_conditioner
module tb_water_level_sensor_conditioner;
  localparam int D = 4;
  localparam int F = 8;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   errors = 0;
  int   checks = 0;

  water_level_sensor_conditioner_if bus ();

  water_level_sensor_conditioner #(
    .DEBOUNCE_CYCLES(D),
    .DB_W(16),
    .FAULT_CYCLES(F),
    .FLT_W(16)
  ) dut (
    .clk(clk),
    .reset(reset),
    .lvl(bus)
  );

  always #5 clk = ~clk;

  // Reference model state: what the conditioner should present after each edge.
  logic [2:0] m_db, m_s;
  logic       m_valid, m_fault, m_lc;
  int         m_fcnt, m_rel, m_cc;
  logic [2:0] raw_hist[$];
  logic [2:0] seen_hist[$];

  function automatic bit is_plaus(input logic [2:0] p);
    return (p == 3'b000) || (p == 3'b001) || (p == 3'b011) || (p == 3'b111);
  endfunction

  task automatic set_raw(input logic [2:0] r);
    {bus.raw_s3, bus.raw_s2, bus.raw_s1} = r;
  endtask

  task automatic model_step();
    logic [2:0] raw_now, seen;
    bit done, all_diff;
    if (!reset) begin
      m_db = 3'b111; m_s = 3'b111; m_valid = 1'b0; m_fault = 1'b0; m_lc = 1'b0;
      m_fcnt = 0; m_rel = 0; m_cc = 0;
      raw_hist = '{3'b111, 3'b111};
      seen_hist.delete();
    end else begin
      raw_now = {bus.raw_s3, bus.raw_s2, bus.raw_s1};
      raw_hist.push_back(raw_now);
      if (raw_hist.size() > 3) void'(raw_hist.pop_front());
      seen = raw_hist[0];
      seen_hist.push_back(seen);
      if (seen_hist.size() > D) void'(seen_hist.pop_front());
      if (m_lc && m_cc != 65535) m_cc++;
      done = (m_rel >= D + 2);
      if (m_rel < 1000) m_rel++;
      if (done && is_plaus(m_db)) begin
        m_lc = (m_db != m_s);
        m_s = m_db;
        m_valid = 1'b1;
        m_fcnt = 0;
        if (bus.fault_clr) m_fault = 1'b0;
      end else if (done) begin
        m_lc = 1'b0;
        m_valid = 1'b0;
        if (m_fcnt < 65535) m_fcnt++;
        if (m_fcnt == F) m_fault = 1'b1;
        else if (bus.fault_clr) m_fault = 1'b0;
        if (bus.fault_clr) m_fcnt = 0;
      end else begin
        m_lc = 1'b0;
        m_valid = 1'b0;
        m_fcnt = 0;
        if (bus.fault_clr) m_fault = 1'b0;
      end
      // A debounced bit follows once the last D synchronised samples all disagree with it.
      for (int b = 0; b < 3; b++) begin
        all_diff = (seen_hist.size() == D);
        foreach (seen_hist[k]) if (seen_hist[k][b] == m_db[b]) all_diff = 1'b0;
        if (all_diff) m_db[b] = ~m_db[b];
      end
    end
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    chk("S", {13'd0, bus.S3, bus.S2, bus.S1}, {13'd0, m_s});
    chk("level_valid", {15'd0, bus.level_valid}, {15'd0, m_valid});
    chk("sensor_fault", {15'd0, bus.sensor_fault}, {15'd0, m_fault});
    chk("level_change", {15'd0, bus.level_change}, {15'd0, m_lc});
`ifdef WATER_LEVEL_CHANGE_COUNT_EN
    chk("change_count", bus.change_count, 16'(m_cc));
`endif
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    logic [2:0] pats [4];
    logic [2:0] r;
    int hold;
    pats[0] = 3'b000; pats[1] = 3'b001; pats[2] = 3'b011; pats[3] = 3'b111;
    set_raw(3'b111);
    bus.fault_clr = 1'b0;

    // Reset and startup window
    ticks(3);
    chk("t1_reset_S", {13'd0, bus.S3, bus.S2, bus.S1}, 16'h7);
    chk("t1_reset_valid", {15'd0, bus.level_valid}, 16'h0);
    reset = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("t1_startup_valid", {15'd0, bus.level_valid}, 16'h0);
    end
    tick();
    chk("t1_valid_7th", {15'd0, bus.level_valid}, 16'h1);

    // Three-cycle glitch on S3 is rejected
    bus.raw_s3 = 1'b0;
    ticks(3);
    bus.raw_s3 = 1'b1;
    ticks(8);
    chk("t2_glitch_S", {13'd0, bus.S3, bus.S2, bus.S1}, 16'h7);

    // 111 -> 011 -> 000 with exact latency
    set_raw(3'b011);
    ticks(6);
    chk("t3_before_S", {13'd0, bus.S3, bus.S2, bus.S1}, 16'h7);
    tick();
    chk("t3_S_011", {13'd0, bus.S3, bus.S2, bus.S1}, 16'h3);
    chk("t3_change", {15'd0, bus.level_change}, 16'h1);
    tick();
    chk("t3_change_end", {15'd0, bus.level_change}, 16'h0);
    chk("t3_valid", {15'd0, bus.level_valid}, 16'h1);
    set_raw(3'b000);
    ticks(7);
    chk("t3_S_000", {13'd0, bus.S3, bus.S2, bus.S1}, 16'h0);
    chk("t3_change2", {15'd0, bus.level_change}, 16'h1);
    set_raw(3'b111);
    ticks(10);

    // Implausible 101 held until sensor_fault, then clear
    set_raw(3'b101);
    ticks(13);
    chk("t4_fault_pre", {15'd0, bus.sensor_fault}, 16'h0);
    tick();
    chk("t4_fault_set", {15'd0, bus.sensor_fault}, 16'h1);
    chk("t4_hold_S", {13'd0, bus.S3, bus.S2, bus.S1}, 16'h7);
    chk("t4_invalid", {15'd0, bus.level_valid}, 16'h0);
    set_raw(3'b111);
    ticks(7);
    chk("t4_valid_back", {15'd0, bus.level_valid}, 16'h1);
    chk("t4_fault_sticky", {15'd0, bus.sensor_fault}, 16'h1);
    bus.fault_clr = 1'b1;
    tick();
    bus.fault_clr = 1'b0;
    chk("t4_fault_clr", {15'd0, bus.sensor_fault}, 16'h0);

    // Clear on the same cycle the fault sets: set wins
    set_raw(3'b101);
    ticks(13);
    bus.fault_clr = 1'b1;
    tick();
    bus.fault_clr = 1'b0;
    chk("t5_set_wins", {15'd0, bus.sensor_fault}, 16'h1);
    set_raw(3'b111);
    ticks(7);
    bus.fault_clr = 1'b1;
    tick();
    bus.fault_clr = 1'b0;

`ifdef WATER_LEVEL_CHANGE_COUNT_EN
    // Change counter counts level_change pulses and clears on reset
    reset = 1'b0;
    ticks(2);
    reset = 1'b1;
    ticks(8);
    chk("t6_cc_zero", bus.change_count, 16'd0);
    set_raw(3'b011); ticks(8);
    set_raw(3'b001); ticks(8);
    set_raw(3'b000); ticks(8);
    chk("t6_cc_three", bus.change_count, 16'd3);
    reset = 1'b0;
    tick();
    chk("t6_cc_reset", bus.change_count, 16'd0);
    reset = 1'b1;
    set_raw(3'b111);
    ticks(8);
`endif

    // Randomised patterns, holds, clears and occasional mid-run resets
    for (int it = 0; it < 400; it++) begin
      if ($urandom_range(0, 3) != 0) r = pats[$urandom_range(0, 3)];
      else r = 3'($urandom_range(0, 7));
      set_raw(r);
      hold = $urandom_range(1, 12);
      for (int h = 0; h < hold; h++) begin
        bus.fault_clr = ($urandom_range(0, 15) == 0);
        tick();
      end
      bus.fault_clr = 1'b0;
      if ($urandom_range(0, 39) == 0) begin
        reset = 1'b0;
        ticks(2);
        reset = 1'b1;
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
